ram_sdp_sync: RTL
=================

# ram_sdp_sync

Single-clock, simple dual-port synchronous RAM: the parametrised successor to the dual-clock 8x64 RAM. It has one write port and one read port, with configurable width, depth, byte-enables, read-during-write semantics and an optional output register stage. An optional hardware clear sequence zeroes the whole array after reset. It serves as the general-purpose buffer memory for single-clock-domain datapaths (FIFOs, line buffers, lookup tables).

## Interface
- DATA_WIDTH, 8: word width in bits; must be a multiple of BYTE_WIDTH
- ADDR_WIDTH, 6: address width; DEPTH = 2**ADDR_WIDTH words
- BYTE_WIDTH, 8: bits per byte-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
- RDW_MODE, 0: same-address read-during-write behaviour; 0 = old data, 1 = new data
- OUT_REG, 0: 1 adds an output register stage to the read path
- CLEAR_ON_RESET, 1: 1 zeroes every word after reset

Ports:
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- we  in  1  write request
- write_addr  in  ADDR_WIDTH  write address
- data  in  DATA_WIDTH  write data
- be  in  NB  byte-lane enables; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- re  in  1  read request
- read_addr  in  ADDR_WIDTH  read address
- q  out  DATA_WIDTH  read data
- q_valid  out  1  one-cycle pulse, aligned with new q
- busy  out  1  clear sequence in progress; requests are ignored while high

## Operation
- States: CLEAR and READY.
- With reset high:
  - next state is CLEAR if CLEAR_ON_RESET=1, else READY.
  - clear counter is 0.
  - q = 0, q_valid = 0, all read pipeline valids = 0.
  - busy = CLEAR_ON_RESET.
  - In-flight reads are discarded.
- CLEAR state:
  - Each cycle writes 0 to all lanes of address cnt, then cnt increments.
  - After the cycle that writes DEPTH-1, the state moves to READY and busy falls.
  - we and re are ignored, with no side effects.
  - Reset asserted mid-clear restarts at address 0.
- READY state, write:
  - Happens when we=1.
  - Lane i of mem[write_addr] is updated from data only when be[i]=1.
  - we=1 with be=0 changes nothing.
- READY state, read:
  - Happens when re=1.
  - mem[read_addr] is captured and presented after the read latency, with q_valid=1 for exactly one cycle.
- q holds its last value when no read completes; q_valid=0 in those cycles.
- Same-address read and write in the same cycle:
  - RDW_MODE=0: q returns the pre-write word.
  - RDW_MODE=1: q returns the merged word, i.e. new bytes where be=1 and old bytes elsewhere.
- Different-address read and write in the same cycle are independent.
- Depth is always a power of two, so no out-of-range addresses exist.
- Addresses do not auto-increment; addressing is fully caller-driven.

## Timing
- Read latency L = 1 + OUT_REG clock edges from the edge sampling re=1 to q/q_valid update.
- Back-to-back reads sustain one per cycle, and q_valid stays high continuously.
- A write is visible to a read issued on the next cycle, in either RDW mode.
- Clear duration:
  - Exactly DEPTH edges after the first edge with reset low.
  - busy is low from edge DEPTH onward.
  - The first accepted request is on the edge after busy falls.
- With CLEAR_ON_RESET=0, busy=0 always, and requests are accepted on the first edge with reset low.
- No combinational path from inputs to outputs.

## Structure
- Shared package ram_pkg holds:
  - RDW_OLD_DATA = 0, RDW_NEW_DATA = 1
  - state enum {ST_CLEAR, ST_READY}
- Sub-module ram_sdp_core: the storage array plus the byte-masked write and the registered raw read (including RDW merge), with no reset on the array.
- The top level holds the clear FSM and counter, the write-port mux (clear vs user), the OUT_REG stage and the valid pipeline.

## Test plan
- **Clear sequence:** ADDR_WIDTH=4, CLEAR_ON_RESET=1; preload garbage, pulse reset 1 cycle.
  - busy high for exactly 16 edges.
  - Subsequent reads of addresses 0..15 all return 0x00 with q_valid.
- **Byte enables:** DATA_WIDTH=32.
  - Write 0xAABBCCDD to addr 3 with be=4'b1111, then 0x11223344 with be=4'b0101.
  - Reading addr 3 returns 0xAA22CC44.
- **Read-during-write:** addr 5 holds 0x12; same cycle: we, data=0x34, be=1, re, both addresses 5.
  - RDW_MODE=0 gives q=0x12.
  - RDW_MODE=1 gives q=0x34.
  - A following read gives 0x34 in both modes.
- **Latency and throughput:** OUT_REG=0 and 1; reads of addresses 0..7 on consecutive cycles.
  - q_valid rises 1 (resp. 2) cycles after the first re and stays high 8 cycles.
  - Data is in order.
- **Requests during clear:** we=1 to addr 2 with data 0xFF, and re=1, both while busy.
  - No q_valid.
  - After busy falls, addr 2 reads 0x00.
- **Reset mid-operation:** assert reset at clear count 7, or with a read in flight.
  - q=0, q_valid=0 the next cycle.
  - Clear restarts and busy lasts a full DEPTH edges.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the simple dual-port synchronous RAM.
//   RDW_OLD_DATA / RDW_NEW_DATA : values for the RDW_MODE parameter
//   state_t                     : top-level clear/ready state encoding
package ram_pkg;

    localparam int RDW_OLD_DATA = 0;
    localparam int RDW_NEW_DATA = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/ram_sdp_core.sv
// ram_sdp_core: storage array with byte-masked write and a registered read.
// Ports:
//   clock, reset : clock and synchronous reset (reset only clears the read register)
//   we, waddr, wdata, wbe : write port; lane i written only when wbe[i]=1
//   re, raddr             : read port; rdata loads mem[raddr] on the edge sampling re=1
//   rdata                 : registered read data, holds when re=0
module ram_sdp_core
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE   = RDW_OLD_DATA
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             we,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
    input  logic                             re,
    input  logic [ADDR_WIDTH-1:0]            raddr,
    output logic [DATA_WIDTH-1:0]            rdata
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;

    // Merged word: the bytes being written this cycle replace the stored ones
    // when the write targets the word being read.
    always_comb begin
        w_old    = r_mem[raddr];
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            if (we && (waddr == raddr) && wbe[i]) begin
                w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    r_mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= (RDW_MODE == RDW_NEW_DATA) ? w_merged : w_old;
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/ram_sdp_sync.sv
// ram_sdp_sync: single-clock simple dual-port RAM with optional clear-after-reset
// and optional output register.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   we, write_addr, data, be : write request, address, data, byte-lane enables
//   re, read_addr         : read request and address
//   q, q_valid            : read data and its one-cycle valid pulse
//   busy                  : clear sequence running; requests ignored
// Request semantics: a request is taken on any rising edge where it is high,
// reset is low and busy is low; there is no back-pressure. Each accepted read
// produces exactly one q_valid pulse 1+OUT_REG edges later, q updating with it.
module ram_sdp_sync
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 6,
    parameter int BYTE_WIDTH     = 8,
    parameter int RDW_MODE       = RDW_OLD_DATA,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             we,
    input  logic [ADDR_WIDTH-1:0]            write_addr,
    input  logic [DATA_WIDTH-1:0]            data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic                             re,
    input  logic [ADDR_WIDTH-1:0]            read_addr,
    output logic [DATA_WIDTH-1:0]            q,
    output logic                             q_valid,
    output logic                             busy
);

    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_busy;
    logic                    r_v1;

    logic                    w_clear;
    logic                    w_user;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_waddr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [NB-1:0]           w_wbe;
    logic                    w_re;
    logic [DATA_WIDTH-1:0]   w_rdata;

    // Clear FSM: walks r_cnt over every address, then parks in ST_READY.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_busy  <= (CLEAR_ON_RESET != 0);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;

    // Write port mux: the clear sequence owns the port while it runs.
    assign w_clear = (r_state == ST_CLEAR) && !reset;
    assign w_user  = (r_state == ST_READY) && !reset;
    assign w_we    = w_clear || (w_user && we);
    assign w_waddr = w_clear ? r_cnt : write_addr;
    assign w_wdata = w_clear ? '0 : data;
    assign w_wbe   = w_clear ? '1 : be;
    assign w_re    = w_user && re;

    ram_sdp_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .RDW_MODE   (RDW_MODE)
    ) u_core (
        .clock (clock),
        .reset (reset),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .wbe   (w_wbe),
        .re    (w_re),
        .raddr (read_addr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_re;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_q;
            logic                  r_v2;
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_q  <= '0;
                    r_v2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_q <= w_rdata;
                    end
                end
            end
            assign q       = r_q;
            assign q_valid = r_v2;
        end else begin : g_no_out_reg
            assign q       = w_rdata;
            assign q_valid = r_v1;
        end
    endgenerate

endmodule
